// File: rtl/dot_pkg.sv
// Shared types and helpers for the vector dot-product engine.
// Helpers work on fixed maximum widths; callers extend or truncate to their own sizes.
package dot_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUTPUT} state_e;

    localparam int unsigned SliceW = 1024;
    localparam int unsigned SatW   = 128;
    localparam int unsigned ResW   = 64;

    // Extract lane idx of a packed vector of width-bit lanes (lane 0 in the LSBs).
    function automatic logic [ResW-1:0] lane_slice(logic [SliceW-1:0] vec, int unsigned idx,
                                                   int unsigned width);
        logic [SliceW-1:0] mask;
        mask = (SliceW'(1) << width) - SliceW'(1);
        return ResW'((vec >> (idx * width)) & mask);
    endfunction

    // Shift then clamp to a width-bit range; returns {overflow, value}.
    function automatic logic [ResW:0] saturate(logic [SatW-1:0] value, int unsigned shift,
                                               logic signed_mode, int unsigned width);
        logic [SatW-1:0] shifted;
        logic [SatW-1:0] hi;
        logic [SatW-1:0] lo;
        logic [SatW-1:0] res;
        logic            ovf;
        ovf = 1'b0;
        if (signed_mode) begin
            shifted = SatW'($signed(value) >>> shift);
            hi      = (SatW'(1) << (width - 1)) - SatW'(1);
            lo      = ~hi;
            if ($signed(shifted) > $signed(hi)) begin
                res = hi;
                ovf = 1'b1;
            end else if ($signed(shifted) < $signed(lo)) begin
                res = lo;
                ovf = 1'b1;
            end else begin
                res = shifted;
            end
        end else begin
            shifted = value >> shift;
            hi      = (SatW'(1) << width) - SatW'(1);
            lo      = '0;
            if (shifted > hi) begin
                res = hi;
                ovf = 1'b1;
            end else begin
                res = shifted;
            end
        end
        return {ovf, ResW'(res)};
    endfunction

endpackage

// File: rtl/vector_dot_mul_stage.sv
// Stages 1-2 of the dot pipeline: per-lane multipliers, then a registered adder tree.
// Never stalls; the valid pipe tracks which stages hold a live beat.
module vector_dot_mul_stage
    import dot_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4,
    localparam int unsigned SumW = 2 * WIDTH + $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   beat_valid,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic                   signed_mode,
    output logic [SumW-1:0]        sum,
    output logic                   sum_valid,
    output logic                   pipe_busy
);

    localparam int unsigned ProdW = 2 * WIDTH;

    logic [WIDTH-1:0]        a_lane    [LANES];
    logic [WIDTH-1:0]        b_lane    [LANES];
    logic signed [ProdW+1:0] prod_full [LANES];
    logic [ProdW-1:0]        prod_q    [LANES];
    logic                    prod_valid_q;
    logic [SumW-1:0]         ext;
    logic [SumW-1:0]         sum_d;
    logic [SumW-1:0]         sum_q;
    logic                    sum_valid_q;

    // One extra bit per operand lets a single signed multiplier serve both modes.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_lane[i]    = WIDTH'(lane_slice(SliceW'(a), i, WIDTH));
            b_lane[i]    = WIDTH'(lane_slice(SliceW'(b), i, WIDTH));
            prod_full[i] = $signed({signed_mode & a_lane[i][WIDTH-1], a_lane[i]}) *
                           $signed({signed_mode & b_lane[i][WIDTH-1], b_lane[i]});
        end
    end

    always_comb begin
        sum_d = '0;
        ext   = '0;
        for (int i = 0; i < LANES; i++) begin
            ext              = {SumW{signed_mode & prod_q[i][ProdW-1]}};
            ext[ProdW-1:0]   = prod_q[i];
            sum_d            = sum_d + ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
            prod_valid_q <= 1'b0;
            sum_q        <= '0;
            sum_valid_q  <= 1'b0;
        end else begin
            prod_valid_q <= beat_valid;
            if (beat_valid) begin
                for (int i = 0; i < LANES; i++) prod_q[i] <= prod_full[i][ProdW-1:0];
            end
            sum_valid_q <= prod_valid_q;
            if (prod_valid_q) sum_q <= sum_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign pipe_busy = prod_valid_q | sum_valid_q;

endmodule

// File: rtl/vector_dot_engine.sv
// Streaming multi-lane dot-product engine: job FSM, beat counter, accumulator and
// shifted/saturated result registers around the multiply/adder-tree stage.
module vector_dot_engine
    import dot_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_BEATS = 256,
    localparam int unsigned ACC_WIDTH = 2 * WIDTH + $clog2(LANES) + $clog2(MAX_BEATS) + 1,
    localparam int unsigned LenW      = $clog2(MAX_BEATS + 1),
    localparam int unsigned ShW       = $clog2(2 * WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [LenW-1:0]        length,
    input  logic                   signed_mode,
    input  logic [ShW-1:0]         shift,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] a_in,
    input  logic [LANES*WIDTH-1:0] b_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       result,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned SumW = 2 * WIDTH + $clog2(LANES);

    state_e               state_q, state_d;
    logic [LenW-1:0]      len_q, cnt_q, len_clamped;
    logic                 mode_q;
    logic [ShW-1:0]       shift_q;
    logic [ACC_WIDTH-1:0] acc_q, sum_ext;
    logic [WIDTH-1:0]     result_q;
    logic [ACC_WIDTH-1:0] acc_out_q;
    logic                 ovf_q;
    logic [SumW-1:0]      sum;
    logic                 sum_valid, pipe_busy;
    logic                 start_ok, accept, last_beat, drain_done;
    logic [SatW-1:0]      acc_wide;
    logic [ResW:0]        sat_res;

    vector_dot_mul_stage #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_mul_stage (
        .clk         (clk),
        .reset_n     (reset_n),
        .beat_valid  (accept),
        .a           (a_in),
        .b           (b_in),
        .signed_mode (mode_q),
        .sum         (sum),
        .sum_valid   (sum_valid),
        .pipe_busy   (pipe_busy)
    );

    assign len_clamped = (length > LenW'(MAX_BEATS)) ? LenW'(MAX_BEATS) : length;
    assign start_ok    = (state_q == IDLE) && start;
    assign accept      = in_valid && in_ready;
    assign last_beat   = accept && ((cnt_q + LenW'(1)) == len_q);
    assign drain_done  = (state_q == DRAIN) && !pipe_busy;

    always_comb begin
        sum_ext             = {ACC_WIDTH{mode_q & sum[SumW-1]}};
        sum_ext[SumW-1:0]   = sum;
        acc_wide            = {SatW{mode_q & acc_q[ACC_WIDTH-1]}};
        acc_wide[ACC_WIDTH-1:0] = acc_q;
        sat_res             = saturate(acc_wide, 32'(shift_q), mode_q, WIDTH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (len_clamped == '0) ? OUTPUT : STREAM;
            STREAM:  if (last_beat) state_d = DRAIN;
            DRAIN:   if (!pipe_busy) state_d = OUTPUT;
            OUTPUT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE:    busy = 1'b0;
            STREAM:  in_ready = 1'b1;
            DRAIN:   ;
            OUTPUT:  res_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            shift_q   <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            acc_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                len_q   <= len_clamped;
                mode_q  <= signed_mode;
                shift_q <= shift;
                cnt_q   <= '0;
                acc_q   <= '0;
            end else begin
                if (accept)    cnt_q <= cnt_q + LenW'(1);
                if (sum_valid) acc_q <= acc_q + sum_ext;
            end
            // Results load once per job, so they hold steady under backpressure.
            if (start_ok && (len_clamped == '0)) begin
                result_q  <= '0;
                acc_out_q <= '0;
                ovf_q     <= 1'b0;
            end else if (drain_done) begin
                result_q  <= WIDTH'(sat_res);
                acc_out_q <= acc_q;
                ovf_q     <= sat_res[ResW];
            end
        end
    end

    assign result   = result_q;
    assign acc_out  = acc_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_vector_dot_engine.sv
// Self-checking bench for vector_dot_engine: directed and random jobs against an
// integer-arithmetic reference model.
module tb_vector_dot_engine;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int MB = 256;
    localparam int AW = 43;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    length = '0;
    logic          signed_mode = 1'b0;
    logic [4:0]    shift = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   a_in = '0;
    logic [63:0]   b_in = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [15:0]   result;
    logic [AW-1:0] acc_out;
    logic          overflow;
    logic          busy;

    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    bit            ready_seen;
    logic [63:0]   ga[$];
    logic [63:0]   gb[$];
    logic [15:0]   last_res;
    logic [AW-1:0] last_acc;
    logic          last_ovf;

    vector_dot_engine #(
        .WIDTH     (W),
        .LANES     (L),
        .MAX_BEATS (MB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .length      (length),
        .signed_mode (signed_mode),
        .shift       (shift),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .acc_out     (acc_out),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (in_ready) ready_seen = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    // Reference: plain integer dot product over all queued beats, then shift and clamp.
    function automatic void model(input bit smode, input int sh, output longint acc,
                                  output logic [15:0] res, output bit ovf);
        longint      v, x, y;
        logic [63:0] wa, wb;
        logic [15:0] la, lb;
        acc = 0;
        for (int k = 0; k < ga.size(); k++) begin
            wa = ga[k];
            wb = gb[k];
            for (int l = 0; l < L; l++) begin
                la = wa[l*16 +: 16];
                lb = wb[l*16 +: 16];
                x = smode ? longint'($signed(la)) : longint'(la);
                y = smode ? longint'($signed(lb)) : longint'(lb);
                acc += x * y;
            end
        end
        v   = acc >>> sh;
        ovf = 1'b0;
        res = v[15:0];
        if (smode) begin
            if (v > 32767)       begin res = 16'h7fff; ovf = 1'b1; end
            else if (v < -32768) begin res = 16'h8000; ovf = 1'b1; end
        end else if (v > 65535) begin
            res = 16'hffff;
            ovf = 1'b1;
        end
    endfunction

    task automatic run_job(input string name, input int req_len, input bit smode, input int sh,
                           input int gap_pct, input int hold);
        int          nb, t, g, s_cyc, hs_cyc, rv_cyc;
        longint      macc;
        logic [15:0] eres, r0;
        bit          eovf;
        logic [AW-1:0] a0;
        logic        o0;
        nb = ga.size();
        model(smode, sh, macc, eres, eovf);
        ready_seen  = 1'b0;
        hs_cyc      = 0;
        start       = 1'b1;
        length      = 9'(req_len);
        signed_mode = smode;
        shift       = 5'(sh);
        s_cyc       = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < nb; k++) begin
            g = 0;
            while (gap_pct > 0 && g < 8 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                tick();
                g++;
            end
            in_valid = 1'b1;
            a_in     = ga[k];
            b_in     = gb[k];
            t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            if (t >= 20) begin
                check({name, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
                break;
            end
            hs_cyc = cyc;
            tick();
        end
        // Keep offering junk beats; none may be consumed.
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
        if (nb > 0) check({name, "_in_ready_drop"}, 64'(in_ready), 64'd0);
        t = 0;
        while (!res_valid && t < 40) begin
            tick();
            t++;
        end
        rv_cyc = cyc;
        if (nb > 0) check({name, "_latency"}, 64'(rv_cyc - hs_cyc), 64'd4);
        else        check({name, "_latency"}, 64'(rv_cyc - s_cyc), 64'd1);
        check({name, "_result"}, 64'(result), 64'(eres));
        check({name, "_acc_out"}, 64'(acc_out), 64'(macc[AW-1:0]));
        check({name, "_overflow"}, 64'(overflow), 64'(eovf));
        last_res = result;
        last_acc = acc_out;
        last_ovf = overflow;
        r0 = result;
        a0 = acc_out;
        o0 = overflow;
        for (int h = 0; h < hold; h++) begin
            start = (h == 2);
            tick();
            check({name, "_hold_res"}, 64'(result), 64'(r0));
            check({name, "_hold_acc"}, 64'(acc_out), 64'(a0));
            check({name, "_hold_ovf"}, 64'(overflow), 64'(o0));
            check({name, "_hold_valid"}, 64'(res_valid), 64'd1);
            check({name, "_hold_busy"}, 64'(busy), 64'd1);
        end
        res_ready = 1'b1;
        start     = 1'b1;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_valid_after"}, 64'(res_valid), 64'd0);
        if (nb == 0) check({name, "_no_ready"}, 64'(ready_seen), 64'd0);
    endtask

    task automatic fill_random(input int n);
        ga.delete();
        gb.delete();
        for (int k = 0; k < n; k++) begin
            ga.push_back({$urandom, $urandom});
            gb.push_back({$urandom, $urandom});
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, 64'(in_ready), 64'd0);
        check({name, "_res_valid"}, 64'(res_valid), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_overflow"}, 64'(overflow), 64'd0);
        check({name, "_result"}, 64'(result), 64'd0);
        check({name, "_acc_out"}, 64'(acc_out), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        tick();
        tick();
        check_reset_outputs("reset");
        #3 reset_n = 1'b1;
        tick();

        // Unsigned 36 case, then the same data with shift 4.
        ga = '{pk(1, 2, 3, 4), pk(5, 6, 7, 8)};
        gb = '{pk(1, 1, 1, 1), pk(1, 1, 1, 1)};
        run_job("u36", 2, 1'b0, 0, 0, 0);
        check("u36_lit_res", 64'(last_res), 64'd36);
        check("u36_lit_acc", 64'(last_acc), 64'd36);
        check("u36_lit_ovf", 64'(last_ovf), 64'd0);
        run_job("u36_sh4", 2, 1'b0, 4, 0, 0);
        check("u36_sh4_lit", 64'(last_res), 64'd2);

        // Signed -2, then the same operands unsigned.
        ga = '{pk(-3, 2, 0, 0)};
        gb = '{pk(4, 5, 0, 0)};
        run_job("sneg", 1, 1'b1, 0, 0, 0);
        check("sneg_lit_res", 64'(last_res), 64'hfffe);
        check("sneg_lit_acc", 64'(last_acc), 64'h7ff_ffff_fffe);
        check("sneg_lit_ovf", 64'(last_ovf), 64'd0);
        run_job("uneg", 1, 1'b0, 0, 0, 0);
        check("uneg_lit_res", 64'(last_res), 64'hffff);
        check("uneg_lit_ovf", 64'(last_ovf), 64'd1);

        // Signed full-scale positive saturation.
        ga = '{pk(32'h7fff, 32'h7fff, 32'h7fff, 32'h7fff)};
        gb = '{pk(32'h7fff, 32'h7fff, 32'h7fff, 32'h7fff)};
        run_job("smax", 1, 1'b1, 0, 0, 0);
        check("smax_lit_acc", 64'(last_acc), 64'h0_fffc_0004);
        check("smax_lit_res", 64'(last_res), 64'h7fff);
        check("smax_lit_ovf", 64'(last_ovf), 64'd1);

        // Gaps plus backpressure.
        fill_random(6);
        run_job("gaps_hold", 6, 1'b1, 3, 40, 5);

        // Zero-length job.
        ga.delete();
        gb.delete();
        run_job("zero", 0, 1'b1, 7, 0, 2);

        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(12, 1);
            fill_random(n);
            run_job($sformatf("rnd%0d", j), n, 1'($urandom_range(1)), $urandom_range(31),
                    $urandom_range(50), $urandom_range(3));
        end

        // Oversized length clamps to MAX_BEATS beats.
        fill_random(MB);
        run_job("clamp", 300, 1'b0, 20, 0, 0);

        // Reset in the middle of streaming, on beat 3 of 8.
        start       = 1'b1;
        length      = 9'd8;
        signed_mode = 1'b0;
        shift       = 5'd0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            a_in     = {$urandom, $urandom};
            b_in     = {$urandom, $urandom};
            t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            tick();
        end
        in_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #3 reset_n = 1'b1;
        in_valid = 1'b0;
        tick();
        check_reset_outputs("post_reset");
        ga = '{pk(10, -20, 30, 40)};
        gb = '{pk(3, 3, -2, 1)};
        run_job("after_reset", 1, 1'b1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vector_dot_engine.md
Name: vector_dot_engine

Overview:
- Streaming, multi-lane dot-product engine; successor to the single-pair dot unit.
- Consumes LANES operand pairs per beat over a valid/ready stream, accumulates at full precision, then presents a shifted, saturated WIDTH-bit result on a valid/ready output.
- Adds signed/unsigned mode, a fixed-point right shift, overflow reporting, zero-length jobs and output backpressure.
- Sits between the operand buffers and the TTPU writeback path.

Parameters:
- WIDTH, 16, operand and result width.
- LANES, 4, operand pairs per beat; power of two, at least 1.
- MAX_BEATS, 256, maximum beats per job.
- ACC_WIDTH (localparam), 2*WIDTH+$clog2(LANES)+$clog2(MAX_BEATS)+1, accumulator width; cannot overflow within a legal job.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; honoured only in IDLE.
- length  in  $clog2(MAX_BEATS+1)  beats in the job; sampled when start is honoured.
- signed_mode  in  1  1 = two's-complement operands; sampled at start.
- shift  in  $clog2(2*WIDTH)  right-shift applied to the accumulator before saturation; sampled at start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat.
- a_in  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- b_in  in  LANES*WIDTH  same packing as a_in.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- result  out  WIDTH  shifted, saturated result.
- acc_out  out  ACC_WIDTH  raw final accumulator.
- overflow  out  1  result was clamped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (reset_n low, immediate): state IDLE; in_ready, res_valid, busy, overflow = 0; result, acc_out, accumulator, beat counter, pipeline valids = 0.
- Reset asserted mid-job aborts the job with no output.
- States:
  - IDLE: start=1 latches length, signed_mode and shift, clears the accumulator, then moves to STREAM (length>0) or OUTPUT (length=0).
  - STREAM: in_ready=1. Each in_valid&&in_ready handshake injects one beat and increments the beat counter. The cycle that accepts beat number length moves to DRAIN, and in_ready drops in the following cycle.
  - DRAIN: in_ready=0. Waits until the pipeline is empty, then moves to OUTPUT.
  - OUTPUT: res_valid=1; result, acc_out and overflow are stable. res_valid&&res_ready returns the engine to IDLE.
- start is ignored outside IDLE, including in the cycle of the output handshake.
- Pipeline: never stalls; bubbles come only from in_valid=0.
  - Stage 1 registers the LANES products, each 2*WIDTH bits, signed or unsigned.
  - Stage 2 registers the adder-tree sum of those products.
  - Stage 3 adds that sum into the accumulator, sign-extended in signed mode.
  - Output registers load in the cycle after the final accumulation.
- Latency: if the last beat handshakes in cycle N, res_valid rises in cycle N+4.
- Zero-length job: start honoured in cycle S gives res_valid in cycle S+1 with result=0, acc_out=0, overflow=0.
- Arithmetic:
  - Shift is arithmetic in signed mode and logical in unsigned mode.
  - Shifted bits are truncated.
  - Saturation limits: signed [-2^(WIDTH-1), 2^(WIDTH-1)-1]; unsigned [0, 2^WIDTH-1].
  - overflow=1 exactly when clamping occurred.
- res_ready held low keeps all outputs unchanged indefinitely.
- in_valid held high during DRAIN or OUTPUT is not consumed.
- A length above MAX_BEATS is clamped to MAX_BEATS.

Decomposition:
- Package dot_pkg: state enum typedef (IDLE, STREAM, DRAIN, OUTPUT); saturate function (value, shift, signed_mode, WIDTH); lane slicing helper.
- Sub-module vector_dot_mul_stage: LANES multipliers plus the registered adder tree (stages 1-2) with a valid pipe. The top level keeps the FSM, counter, accumulator and output registers.

Test Plan:
- Unsigned, shift 0, length 2, a={1,2,3,4} then {5,6,7,8}, b all 1 -> result 36, acc_out 36, overflow 0, res_valid exactly 4 cycles after the last handshake.
- Signed, length 1, a={-3,2,0,0}, b={4,5,0,0} -> result 16'hFFFE (-2), overflow 0. Repeat in unsigned mode -> overflow 1, result 16'hFFFF.
- Signed, a and b all 16'h7FFF, length 1 -> acc_out 4*32'h3FFF0001, result 16'h7FFF, overflow 1. Rerun with shift 4 on the 36 case -> result 2.
- Random in_valid gaps plus res_ready held low for 5 cycles -> correct sum, outputs stable, busy=1, start pulses ignored; after the handshake, busy=0 next cycle.
- length=0 -> res_valid in cycle S+1, result 0, in_ready never asserted.
- reset_n pulled low during STREAM on beat 3 of 8 -> all outputs at reset values immediately; a subsequent 1-beat job returns the correct result.
